objects_mux_n: RTL and testbench
================================

Name: objects_mux_n

Overview:
- Parametrised N-layer successor to the fixed player/rope/background pixel mux in the VGA path.
- Per pixel, picks the highest-priority enabled layer that is requesting and not transparent; falls back to background.
- Expands RGB332 to 24-bit RGB.
- Accumulates per-frame pairwise overlap (collision) flags and publishes them at frame start for game logic.

Parameters:
- NUM_LAYERS, 4, number of object layers; index 0 = highest priority; legal 2..8
- TRANSPARENT_RGB, 8'hFF, layer colour treated as "not drawing" even when its request is high
- IDX_W, $clog2(NUM_LAYERS+1), width of topLayerIdx

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame
- layerEnable  in  NUM_LAYERS  per-layer mask; 0 removes the layer from selection and collision
- drawingRequest  in  NUM_LAYERS  per-layer request, bit k = layer k
- layerRGB  in  8*NUM_LAYERS  RGB332 per layer, layer k at [8k+7:8k]
- backGroundRGB  in  8  RGB332 background
- redOut  out  8  expanded red
- greenOut  out  8  expanded green
- blueOut  out  8  expanded blue
- topLayerIdx  out  IDX_W  winning layer index; NUM_LAYERS = background
- collisionFlags  out  NUM_LAYERS*NUM_LAYERS  previous-frame snapshot; bit i*NUM_LAYERS+j set iff layers i<j overlapped
- collisionPulse  out  1  one-cycle pulse when a non-zero snapshot is published

Behaviour:
- Reset (asynchronous, active-high): every output is 0, all pipeline registers are 0, and the collision accumulator is 0. Registers clear immediately and stay cleared while reset is high.
- Effective request for layer k: act[k] = drawingRequest[k] & layerEnable[k] & (layerRGB[k] != TRANSPARENT_RGB).
- Stage 1, registered: act, layerRGB, backGroundRGB and startOfFrame are captured.
- Stage 2, registered:
  - Priority encode of act, lowest index wins, writes topLayerIdx and the selected RGB332.
  - No act bit set: background is selected and topLayerIdx = NUM_LAYERS.
- Colour outputs are combinational from the stage-2 RGB332:
  - redOut = {r,r,r[2:1]}
  - greenOut = {g,g,g[2:1]}
  - blueOut = {b,b,b,b}
  - Here r = rgb[7:5], g = rgb[4:2], b = rgb[1:0].
  - 8'h00 maps to 000000; 8'hFF maps to FFFFFF.
- Latency: 2 clocks from inputs to redOut/greenOut/blueOut/topLayerIdx. Fully pipelined, one pixel per clock, no stalls.
- Collision accumulator:
  - Updated from stage-1 act each cycle: acc[i*N+j] |= act[i] & act[j] for i<j.
  - Bits with i>=j are always 0.
- Frame publish, on the cycle the stage-1 startOfFrame is high:
  - collisionFlags <= acc | current-pixel pairs is NOT used. Instead collisionFlags <= acc, and acc <= pairs of the current pixel only. The startOfFrame pixel belongs to the new frame.
  - collisionPulse <= (acc != 0) on the same edge; it is 0 on every other cycle.
- Back-to-back startOfFrame pulses: each pulse publishes the accumulated value, which is at most one pixel's pairs.
- Reset mid-frame discards the accumulator. collisionFlags stays 0 until the next startOfFrame.
- layerEnable and TRANSPARENT_RGB gating apply identically to pixel selection and collision.

Optional Feature:
- Macro OBJECTS_MUX_COLLISION_EN.
- Defined: the collision accumulator, the snapshot and the pulse are implemented as described above.
- Undefined: no collision logic is synthesised; collisionFlags and collisionPulse are tied to 0. The pixel path and its latency are unchanged.

Test Plan:
- N=4; reset high then released; no requests; backGroundRGB=8'h1C -> after 2 clocks red=00, green=FF, blue=00, topLayerIdx=4.
- drawingRequest=4'b0110, layerRGB[1]=8'hE0, layerRGB[2]=8'h03, all enabled -> 2 clocks later red=FF, green=00, blue=00, topLayerIdx=1.
- Same stimulus with layerRGB[1]=8'hFF (transparent) -> layer 2 wins: blue=FF, topLayerIdx=2.
- Same stimulus with layerEnable=4'b1101 -> layer 2 wins.
- Frame 1: layers 0 and 3 overlap for 5 pixels. Then startOfFrame -> collisionFlags bit 3 (0*4+3) = 1, all other bits 0, collisionPulse high exactly 1 clock.
- Next frame has no overlap; then startOfFrame -> collisionFlags=0 and no pulse.
- Assert reset mid-frame after an overlap; release; startOfFrame -> collisionFlags=0 and no pulse. All outputs were 0 while reset was high.

Source files
------------

// File: rtl/objects_mux_n.sv
// N-layer priority pixel mux with RGB332 to RGB888 expansion and a 2-clock pixel pipeline.
// Per-frame pairwise collision flags are built only when OBJECTS_MUX_COLLISION_EN is defined.
module objects_mux_n #(
    parameter int         NUM_LAYERS      = 4,
    parameter logic [7:0] TRANSPARENT_RGB = 8'hFF,
    parameter int         IDX_W           = $clog2(NUM_LAYERS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             startOfFrame,
    input  logic [NUM_LAYERS-1:0]            layerEnable,
    input  logic [NUM_LAYERS-1:0]            drawingRequest,
    input  logic [8*NUM_LAYERS-1:0]          layerRGB,
    input  logic [7:0]                       backGroundRGB,
    output logic [7:0]                       redOut,
    output logic [7:0]                       greenOut,
    output logic [7:0]                       blueOut,
    output logic [IDX_W-1:0]                 topLayerIdx,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] collisionFlags,
    output logic                             collisionPulse
);

    localparam int NN = NUM_LAYERS * NUM_LAYERS;

    logic [NUM_LAYERS-1:0]   act;
    logic [NUM_LAYERS-1:0]   act_s1;
    logic [8*NUM_LAYERS-1:0] rgb_s1;
    logic [7:0]              bg_s1;
    logic [IDX_W-1:0]        sel_idx;
    logic [7:0]              sel_rgb;
    logic [7:0]              rgb_s2;

    // A layer only counts when requested, enabled and not painting the transparent key.
    always_comb begin
        act = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            act[k] = drawingRequest[k] & layerEnable[k] &
                     (layerRGB[8*k +: 8] != TRANSPARENT_RGB);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_s1 <= '0;
            rgb_s1 <= '0;
            bg_s1  <= '0;
        end else begin
            act_s1 <= act;
            rgb_s1 <= layerRGB;
            bg_s1  <= backGroundRGB;
        end
    end

    // Scanning downwards lets the lowest active index overwrite any higher one.
    always_comb begin
        sel_idx = IDX_W'(NUM_LAYERS);
        sel_rgb = bg_s1;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (act_s1[k]) begin
                sel_idx = IDX_W'(k);
                sel_rgb = rgb_s1[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            topLayerIdx <= '0;
            rgb_s2      <= '0;
        end else begin
            topLayerIdx <= sel_idx;
            rgb_s2      <= sel_rgb;
        end
    end

    assign redOut   = {rgb_s2[7:5], rgb_s2[7:5], rgb_s2[7:6]};
    assign greenOut = {rgb_s2[4:2], rgb_s2[4:2], rgb_s2[4:3]};
    assign blueOut  = {4{rgb_s2[1:0]}};

`ifdef OBJECTS_MUX_COLLISION_EN
    logic          sof_s1;
    logic [NN-1:0] pairs;
    logic [NN-1:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sof_s1 <= 1'b0;
        end else begin
            sof_s1 <= startOfFrame;
        end
    end

    always_comb begin
        pairs = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                pairs[i*NUM_LAYERS + j] = act_s1[i] & act_s1[j];
            end
        end
    end

    // The start-of-frame pixel seeds the new accumulator rather than the published one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc            <= '0;
            collisionFlags <= '0;
            collisionPulse <= 1'b0;
        end else if (sof_s1) begin
            acc            <= pairs;
            collisionFlags <= acc;
            collisionPulse <= |acc;
        end else begin
            acc            <= acc | pairs;
            collisionPulse <= 1'b0;
        end
    end
`else
    // Frame timing has no consumer without the collision logic.
    logic unused_sof;
    assign unused_sof     = startOfFrame;
    assign collisionFlags = '0;
    assign collisionPulse = 1'b0;
`endif

endmodule

// File: tb/tb_objects_mux_n.sv
// Self-checking bench for objects_mux_n: directed test-plan steps then random pixels,
// compared against a queue-free reference model; collision checks follow OBJECTS_MUX_COLLISION_EN.
module tb_objects_mux_n;

    localparam int N  = 4;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic [N-1:0]  layerEnable;
    logic [N-1:0]  drawingRequest;
    logic [8*N-1:0] layerRGB;
    logic [7:0]    backGroundRGB;
    logic [7:0]    redOut;
    logic [7:0]    greenOut;
    logic [7:0]    blueOut;
    logic [2:0]    topLayerIdx;
    logic [NN-1:0] collisionFlags;
    logic          collisionPulse;

    typedef struct {
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic [2:0]    idx;
        logic [NN-1:0] flags;
        logic          pulse;
    } exp_t;

    exp_t          prev_exp;
    bit            frame_ovl [N][N];
    logic [NN-1:0] snapshot;
    int            errors = 0;
    int            checks = 0;

    objects_mux_n #(.NUM_LAYERS(N), .TRANSPARENT_RGB(8'hFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .layerEnable   (layerEnable),
        .drawingRequest(drawingRequest),
        .layerRGB      (layerRGB),
        .backGroundRGB (backGroundRGB),
        .redOut        (redOut),
        .greenOut      (greenOut),
        .blueOut       (blueOut),
        .topLayerIdx   (topLayerIdx),
        .collisionFlags(collisionFlags),
        .collisionPulse(collisionPulse)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] expand3(input int v);
        return 8'(v * 36 + v / 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        logic [NN-1:0] ef;
        logic          ep;
`ifdef OBJECTS_MUX_COLLISION_EN
        ef = e.flags;
        ep = e.pulse;
`else
        ef = '0;
        ep = 1'b0;
`endif
        checkOutput({tag, ".red"},   32'(redOut),         32'(e.r));
        checkOutput({tag, ".green"}, 32'(greenOut),       32'(e.g));
        checkOutput({tag, ".blue"},  32'(blueOut),        32'(e.b));
        checkOutput({tag, ".idx"},   32'(topLayerIdx),    32'(e.idx));
        checkOutput({tag, ".flags"}, 32'(collisionFlags), 32'(ef));
        checkOutput({tag, ".pulse"}, 32'(collisionPulse), 32'(ep));
    endtask

    // Reference: winner and colour from the priority rule, collision as a per-frame overlap table.
    function automatic exp_t modelPixel(input logic sof, input logic [N-1:0] en, input logic [N-1:0] dr,
                                        input logic [8*N-1:0] rgbs, input logic [7:0] bg);
        exp_t       e;
        bit         active [N];
        bit         any_ovl;
        int         win;
        logic [7:0] px;
        win = N;
        for (int k = 0; k < N; k++) begin
            active[k] = dr[k] && en[k] && (rgbs[8*k +: 8] != 8'hFF);
            if (active[k] && win == N) win = k;
        end
        px    = (win == N) ? bg : rgbs[8*win +: 8];
        e.r   = expand3(int'(px[7:5]));
        e.g   = expand3(int'(px[4:2]));
        e.b   = 8'(int'(px[1:0]) * 85);
        e.idx = 3'(win);
        e.pulse = 1'b0;
        if (sof) begin
            any_ovl  = 1'b0;
            snapshot = '0;
            for (int i = 0; i < N; i++)
                for (int j = i + 1; j < N; j++)
                    if (frame_ovl[i][j]) begin
                        snapshot[i*N + j] = 1'b1;
                        any_ovl = 1'b1;
                    end
            e.pulse = any_ovl;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    frame_ovl[i][j] = 1'b0;
        end
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (active[i] && active[j]) frame_ovl[i][j] = 1'b1;
        e.flags = snapshot;
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input logic sof, input logic [N-1:0] en,
                                 input logic [N-1:0] dr, input logic [8*N-1:0] rgbs, input logic [7:0] bg);
        exp_t cur;
        startOfFrame   = sof;
        layerEnable    = en;
        drawingRequest = dr;
        layerRGB       = rgbs;
        backGroundRGB  = bg;
        cur = modelPixel(sof, en, dr, rgbs, bg);
        @(posedge clk);
        #1;
        checkAll(tag, prev_exp);
        prev_exp = cur;
    endtask

    task automatic doReset(input int hold);
        exp_t zero_e;
        zero_e = '{r: 8'h00, g: 8'h00, b: 8'h00, idx: 3'd0, flags: '0, pulse: 1'b0};
        reset = 1'b1;
        #1;
        checkAll("reset_async", zero_e);
        repeat (hold) @(posedge clk);
        #1;
        checkAll("reset_hold", zero_e);
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                frame_ovl[i][j] = 1'b0;
        snapshot = '0;
        prev_exp = '{r: 8'h00, g: 8'h00, b: 8'h00, idx: 3'(N), flags: '0, pulse: 1'b0};
    endtask

    initial begin
        logic [N-1:0]   r_en;
        logic [N-1:0]   r_dr;
        logic [8*N-1:0] r_rgb;
        reset          = 1'b0;
        startOfFrame   = 1'b0;
        layerEnable    = '0;
        drawingRequest = '0;
        layerRGB       = '0;
        backGroundRGB  = '0;
        #3;
        doReset(2);

        repeat (3) applyStimulus("bg_only", 1'b0, 4'hF, 4'b0000, 32'h0, 8'h1C);
        repeat (3) applyStimulus("layer1", 1'b0, 4'hF, 4'b0110, {8'h00, 8'h03, 8'hE0, 8'h00}, 8'h1C);
        repeat (3) applyStimulus("transp1", 1'b0, 4'hF, 4'b0110, {8'h00, 8'h03, 8'hFF, 8'h00}, 8'h1C);
        repeat (3) applyStimulus("disable1", 1'b0, 4'b1101, 4'b0110, {8'h00, 8'h03, 8'hE0, 8'h00}, 8'h1C);

        applyStimulus("sof_a", 1'b1, 4'hF, 4'b0000, 32'h0, 8'h00);
        repeat (5) applyStimulus("ovl03", 1'b0, 4'hF, 4'b1001, {8'h03, 8'h00, 8'h00, 8'hE0}, 8'h00);
        repeat (3) applyStimulus("idle_a", 1'b0, 4'hF, 4'b0000, 32'h0, 8'h00);
        applyStimulus("sof_b", 1'b1, 4'hF, 4'b0000, 32'h0, 8'h00);
        repeat (4) applyStimulus("idle_b", 1'b0, 4'hF, 4'b0001, 32'h0000_0055, 8'h00);
        applyStimulus("sof_c", 1'b1, 4'hF, 4'b0000, 32'h0, 8'h00);
        repeat (3) applyStimulus("idle_c", 1'b0, 4'hF, 4'b0000, 32'h0, 8'h00);

        repeat (2) applyStimulus("ovl_pre_rst", 1'b0, 4'hF, 4'b0011, {8'h00, 8'h00, 8'h12, 8'h34}, 8'h00);
        doReset(2);
        applyStimulus("sof_d", 1'b1, 4'hF, 4'b0000, 32'h0, 8'h00);
        repeat (3) applyStimulus("idle_d", 1'b0, 4'hF, 4'b0000, 32'h0, 8'h00);

        for (int n = 0; n < 300; n++) begin
            r_en = N'($urandom | $urandom);
            r_dr = N'($urandom);
            for (int k = 0; k < N; k++)
                r_rgb[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            applyStimulus("random", ($urandom_range(0, 15) == 0), r_en, r_dr, r_rgb, 8'($urandom));
        end
        repeat (3) applyStimulus("drain", 1'b1, 4'hF, 4'b0000, 32'h0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
